// File: rtl/bus_stream_ctrl.sv
// Register-programmed rx->tx byte stream with per-frame transform,
// pipelined output, frame and beat counters on a 16-bit register bus.
module bus_stream_ctrl #(
  parameter int DATA_W     = 8,
  parameter int PIPE_DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_cmd_valid,
  input  logic              bus_op,
  input  logic [15:0]       bus_addr,
  input  logic [15:0]       bus_wr_data,
  output logic [15:0]       bus_rd_data,
  input  logic [DATA_W-1:0] rxd,
  input  logic              rx_dv,
  output logic [DATA_W-1:0] txd,
  output logic              tx_en
);

  localparam logic [15:0] A_CNT_HI = 16'h0005;
  localparam logic [15:0] A_CNT_LO = 16'h0006;
  localparam logic [15:0] A_CTRL   = 16'h0009;
  localparam logic [15:0] A_KEY    = 16'h000A;
  localparam logic [15:0] A_BEAT   = 16'h000B;
  localparam logic [15:0] A_INFO   = 16'h000C;

  localparam logic [15:0] INFO = {4'b0, 4'(PIPE_DEPTH),
                                  3'b0, 5'(DATA_W)};

  logic [1:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic              inv_a_q, xen_a_q;
  logic [DATA_W-1:0] key_a_q;
  logic [31:0]       fcnt_q, fcnt_d;
  logic [15:0]       sh_q, sh_d;
  logic [15:0]       beat_q, beat_d;
  logic [15:0]       rd_q, rd_d;
  logic              dv_q;
  logic [DATA_W-1:0] pd_q [PIPE_DEPTH];
  logic              pv_q [PIPE_DEPTH];

  logic              wr, rd, fend;
  logic [15:0]       key_rd;
  logic [DATA_W-1:0] d1, dout;

  always_comb begin
    wr   = bus_cmd_valid & bus_op;
    rd   = bus_cmd_valid & ~bus_op;
    fend = ~rx_dv & dv_q;

    d1   = inv_a_q ? ~rxd : rxd;
    dout = xen_a_q ? (d1 ^ key_a_q) : d1;

    key_rd = '0;
    key_rd[DATA_W-1:0] = key_q;

    ctrl_d = ctrl_q;
    key_d  = key_q;
    if (wr && bus_addr == A_CTRL) ctrl_d = bus_wr_data[1:0];
    if (wr && bus_addr == A_KEY)  key_d  = bus_wr_data[DATA_W-1:0];

    // commit beats a coincident frame-end increment
    fcnt_d = fcnt_q;
    if (fend) fcnt_d = fcnt_q + 32'd1;
    if (wr && bus_addr == A_CNT_LO) fcnt_d = {sh_q, bus_wr_data};

    sh_d = sh_q;
    if (wr && bus_addr == A_CNT_HI) sh_d = bus_wr_data;
    if (rd && bus_addr == A_CNT_LO) sh_d = fcnt_q[31:16];

    beat_d = beat_q;
    if (rx_dv && beat_q != 16'hFFFF) beat_d = beat_q + 16'd1;
    if (wr && bus_addr == A_BEAT) beat_d = '0;

    rd_d = rd_q;
    if (rd) begin
      case (bus_addr)
        A_CNT_HI: rd_d = sh_q;
        A_CNT_LO: rd_d = fcnt_q[15:0];
        A_CTRL:   rd_d = {14'b0, ctrl_q};
        A_KEY:    rd_d = key_rd;
        A_BEAT:   rd_d = beat_q;
        A_INFO:   rd_d = INFO;
        default:  rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      key_q   <= '0;
      inv_a_q <= 1'b0;
      xen_a_q <= 1'b0;
      key_a_q <= '0;
      fcnt_q  <= '0;
      sh_q    <= '0;
      beat_q  <= '0;
      rd_q    <= '0;
      dv_q    <= 1'b0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pd_q[i] <= '0;
        pv_q[i] <= 1'b0;
      end
    end else begin
      ctrl_q <= ctrl_d;
      key_q  <= key_d;
      fcnt_q <= fcnt_d;
      sh_q   <= sh_d;
      beat_q <= beat_d;
      rd_q   <= rd_d;
      dv_q   <= rx_dv;
      // active config only follows the registers between frames
      if (!rx_dv) begin
        inv_a_q <= ctrl_q[0];
        xen_a_q <= ctrl_q[1];
        key_a_q <= key_q;
      end
      pd_q[0] <= dout;
      pv_q[0] <= rx_dv;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pd_q[i] <= pd_q[i-1];
        pv_q[i] <= pv_q[i-1];
      end
    end
  end

  assign bus_rd_data = rd_q;
  assign txd         = pd_q[PIPE_DEPTH-1];
  assign tx_en       = pv_q[PIPE_DEPTH-1];

endmodule
